// File: rtl/ram_pkg.sv
// Shared types and sizes for the dual-port RAM responder.
// Used by the interface, the RAM store, the top and the bench.
package ram_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
endpackage

// File: rtl/ram_dp_resp_if.sv
// RAM bus: cs/wen/ren/waddr/wdata/raddr from the driver (master),
// rdata/rvalid/rerr back from the responder (slave).
interface ram_if;
  import ram_pkg::*;

  logic  cs;
  logic  wen;
  logic  ren;
  addr_t waddr;
  data_t wdata;
  addr_t raddr;
  data_t rdata;
  logic  rvalid;
  logic  rerr;

  modport master (
    output cs, wen, ren,
    output waddr, wdata, raddr,
    input  rdata, rvalid, rerr
  );

  modport slave (
    input  cs, wen, ren,
    input  waddr, wdata, raddr,
    output rdata, rvalid, rerr
  );
endinterface

// File: rtl/ram_store.sv
// Word storage plus per-entry written flags, async-cleared.
// Ports: clk, rst (active-low), we/waddr/wdata, raddr -> rd_data/rd_written.
module ram_store
  import ram_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  addr_t waddr,
  input  data_t wdata,
  input  addr_t raddr,
  output data_t rd_data,
  output logic  rd_written
);

  data_t            mem [DEPTH];
  logic [DEPTH-1:0] written;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      written <= '0;
    end else if (we) begin
      mem[waddr]     <= wdata;
      written[waddr] <= 1'b1;
    end
  end

  assign rd_data    = mem[raddr];
  assign rd_written = written[raddr];

endmodule

// File: rtl/ram_dp_resp.sv
// Simple-dual-port RAM responder with registered read, valid and
// never-written error strobe. Ports: clk, rst (active-low), bus (slave).
module ram_dp_resp
  import ram_pkg::*;
(
  input  logic clk,
  input  logic rst,
  ram_if.slave bus
);

  logic  wr;
  logic  rd;
  logic  hit;
  data_t mem_q;
  logic  wrt_q;

  assign wr  = bus.cs & bus.wen;
  assign rd  = bus.cs & bus.ren;
  assign hit = wr && (bus.waddr == bus.raddr);

  ram_store u_store (
    .clk        (clk),
    .rst        (rst),
    .we         (wr),
    .waddr      (bus.waddr),
    .wdata      (bus.wdata),
    .raddr      (bus.raddr),
    .rd_data    (mem_q),
    .rd_written (wrt_q)
  );

  // Write-first on collision: the incoming word is returned
  // and counts as written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
      bus.rerr   <= 1'b0;
    end else begin
      bus.rvalid <= rd;
      bus.rerr   <= rd & ~(hit | wrt_q);
      if (rd) begin
        bus.rdata <= hit ? bus.wdata : mem_q;
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_resp.sv
// Self-checking bench for ram_dp_resp against an array model.
// Drives #1 after posedge, samples #1 after posedge.
module tb_ram_dp_resp;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  data_t mdl [DEPTH];
  bit    wflag [DEPTH];
  data_t exp_rdata;
  logic  exp_rvalid;
  logic  exp_rerr;

  ram_if bus ();

  ram_dp_resp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i]   = '0;
      wflag[i] = 1'b0;
    end
    exp_rdata  = '0;
    exp_rvalid = 1'b0;
    exp_rerr   = 1'b0;
  endtask

  // Apply one set of inputs across a rising edge and advance the model.
  task automatic do_edge(input logic c, input logic w, input logic r,
                         input addr_t wa, input data_t wd,
                         input addr_t ra);
    bit do_wr;
    bit do_rd;
    bus.cs    = c;
    bus.wen   = w;
    bus.ren   = r;
    bus.waddr = wa;
    bus.wdata = wd;
    bus.raddr = ra;
    @(posedge clk);
    #1;
    do_wr = c && w;
    do_rd = c && r;
    exp_rvalid = do_rd;
    exp_rerr   = 1'b0;
    if (do_rd) begin
      if (do_wr && wa == ra) begin
        exp_rdata = wd;
      end else begin
        exp_rdata = mdl[ra];
        exp_rerr  = !wflag[ra];
      end
    end
    if (do_wr) begin
      mdl[wa]   = wd;
      wflag[wa] = 1'b1;
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b0;
    do_edge(1, 1, 1, 4'd2, 8'h77, 4'd2);
    do_edge(1, 0, 1, 4'd2, 8'h00, 4'd2);
    checks++;
    if ({bus.rdata, bus.rvalid, bus.rerr} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got %h/%b/%b want 00/0/0",
               bus.rdata, bus.rvalid, bus.rerr);
    end
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_unwritten();
    do_edge(1, 0, 1, 4'd0, 8'h00, 4'd3);
    checks++;
    if ({bus.rdata, bus.rvalid, bus.rerr} !== {8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL unwritten_read got %h/%b/%b want 00/1/1",
               bus.rdata, bus.rvalid, bus.rerr);
    end
  endtask

  task automatic test_write_read();
    do_edge(1, 1, 0, 4'd3, 8'hA5, 4'd0);
    checks++;
    if (bus.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL write_no_rvalid got %b want 0", bus.rvalid);
    end
    do_edge(1, 0, 1, 4'd0, 8'h00, 4'd3);
    checks++;
    if ({bus.rdata, bus.rvalid, bus.rerr} !== {8'hA5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL write_read got %h/%b/%b want a5/1/0",
               bus.rdata, bus.rvalid, bus.rerr);
    end
  endtask

  task automatic test_collision();
    do_edge(1, 1, 1, 4'd7, 8'h5A, 4'd7);
    checks++;
    if ({bus.rdata, bus.rvalid, bus.rerr} !== {8'h5A, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL collision got %h/%b/%b want 5a/1/0",
               bus.rdata, bus.rvalid, bus.rerr);
    end
    do_edge(1, 1, 1, 4'd1, 8'h99, 4'd3);
    checks++;
    if ({bus.rdata, bus.rvalid, bus.rerr} !== {8'hA5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL diff_addr_rw got %h/%b/%b want a5/1/0",
               bus.rdata, bus.rvalid, bus.rerr);
    end
    do_edge(1, 0, 1, 4'd0, 8'h00, 4'd7);
    checks++;
    if ({bus.rdata, bus.rvalid, bus.rerr} !== {8'h5A, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL collision_reread got %h/%b/%b want 5a/1/0",
               bus.rdata, bus.rvalid, bus.rerr);
    end
  endtask

  task automatic test_cs_back_to_back();
    do_edge(1, 1, 0, 4'd0, 8'h11, 4'd0);
    do_edge(1, 1, 0, 4'd15, 8'hFF, 4'd0);
    do_edge(0, 1, 1, 4'd0, 8'h22, 4'd0);
    checks++;
    if ({bus.rvalid, bus.rerr} !== 2'b00) begin
      errors++;
      $display("FAIL cs_low_strobes got %b/%b want 0/0",
               bus.rvalid, bus.rerr);
    end
    do_edge(1, 0, 1, 4'd0, 8'h00, 4'd0);
    checks++;
    if ({bus.rdata, bus.rvalid, bus.rerr} !== {8'h11, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_first got %h/%b/%b want 11/1/0",
               bus.rdata, bus.rvalid, bus.rerr);
    end
    do_edge(1, 0, 1, 4'd0, 8'h00, 4'd15);
    checks++;
    if ({bus.rdata, bus.rvalid, bus.rerr} !== {8'hFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second got %h/%b/%b want ff/1/0",
               bus.rdata, bus.rvalid, bus.rerr);
    end
  endtask

  task automatic test_reset_mid();
    do_edge(1, 0, 0, 4'd0, 8'h00, 4'd0);
    bus.cs    = 1'b1;
    bus.ren   = 1'b1;
    bus.raddr = 4'd3;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.rdata, bus.rvalid, bus.rerr} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_async got %h/%b/%b want 00/0/0",
               bus.rdata, bus.rvalid, bus.rerr);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_edge rvalid got %b want 0", bus.rvalid);
    end
    model_reset();
    rst = 1'b1;
    do_edge(1, 0, 1, 4'd0, 8'h00, 4'd3);
    checks++;
    if ({bus.rdata, bus.rvalid, bus.rerr} !== {8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL post_reset_read got %h/%b/%b want 00/1/1",
               bus.rdata, bus.rvalid, bus.rerr);
    end
  endtask

  task automatic test_idle();
    do_edge(1, 1, 0, 4'd9, 8'h3C, 4'd0);
    do_edge(1, 0, 1, 4'd0, 8'h00, 4'd9);
    for (int i = 0; i < 3; i++) begin
      do_edge(1, 0, 0, 4'd9, 8'hEE, 4'd9);
      checks++;
      if ({bus.rdata, bus.rvalid, bus.rerr} !== {8'h3C, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL idle_hold[%0d] got %h/%b/%b want 3c/0/0",
                 i, bus.rdata, bus.rvalid, bus.rerr);
      end
    end
  endtask

  task automatic test_random();
    addr_t wa;
    addr_t ra;
    for (int i = 0; i < 400; i++) begin
      wa = addr_t'($urandom_range(0, DEPTH - 1));
      ra = ($urandom_range(0, 3) == 0) ? wa
           : addr_t'($urandom_range(0, DEPTH - 1));
      do_edge(logic'($urandom_range(0, 7) != 0),
              logic'($urandom_range(0, 2) == 0),
              logic'($urandom_range(0, 1)),
              wa, data_t'($urandom), ra);
      checks++;
      if ({bus.rdata, bus.rvalid, bus.rerr}
          !== {exp_rdata, exp_rvalid, exp_rerr}) begin
        errors++;
        $display("FAIL random[%0d] got %h/%b/%b want %h/%b/%b", i,
                 bus.rdata, bus.rvalid, bus.rerr,
                 exp_rdata, exp_rvalid, exp_rerr);
      end
    end
  endtask

  initial begin
    bus.cs    = 1'b0;
    bus.wen   = 1'b0;
    bus.ren   = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.raddr = '0;
    test_reset();
    test_unwritten();
    test_write_read();
    test_collision();
    test_cs_back_to_back();
    test_reset_mid();
    test_idle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
